// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
// Imported by the controller and its skew sub-module.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN
  } ctrl_state_e;

  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/valid_skew.sv
// N-tap shift register turning one valid into a staircase vector.
// Tap i carries the input delayed by i + DEPTH_OFFSET cycles.
module valid_skew
  import systolic_pkg::*;
#(
  parameter int N            = 4,
  parameter int DEPTH_OFFSET = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic [N-1:0] out_valid
);

  localparam int D = N + DEPTH_OFFSET - 1;

  logic [D-1:0] sr_q;
  logic [D-1:0] sr_d;

  always_comb begin
    sr_d = {sr_q[D-2:0], in_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out_valid = sr_q[D-1:DEPTH_OFFSET-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an output-stationary N x N systolic MAC array:
// clear, skewed operand feed, wavefront flush, row-by-row drain.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int KW = 16,
  parameter int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          done,
  output logic          acc_clear_block,
  output logic          feed_en,
  output logic [KW-1:0] feed_k,
  output logic [N-1:0]  a_valid_row,
  output logic [N-1:0]  b_valid_col,
  output logic          drain_en,
  output logic [RW-1:0] drain_row,
  input  logic          res_ready
);

  localparam int FLUSH_N = flush_cycles(N);
  localparam int FW      = $clog2(FLUSH_N + 1);

  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_N - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  ctrl_state_e   state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] feed_k_q, feed_k_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          clear_q, clear_d;
  logic          feed_q, feed_d;
  logic          drain_q, drain_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    feed_k_d = feed_k_q;
    flush_d  = flush_q;
    row_d    = row_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d = k_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        feed_k_d = '0;
        row_d    = '0;
        state_d  = (k_len_q != '0) ? FEED : DRAIN;
      end
      FEED: begin
        if (feed_k_q == k_len_q - KW'(1)) begin
          feed_k_d = '0;
          flush_d  = FLUSH_LAST;
          state_d  = FLUSH;
        end else begin
          feed_k_d = feed_k_q + KW'(1);
        end
      end
      FLUSH: begin
        if (flush_q == '0) begin
          row_d   = '0;
          state_d = DRAIN;
        end else begin
          flush_d = flush_q - FW'(1);
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Output flops follow the next state so they change on edges only
    clear_d = (state_d == CLEAR);
    feed_d  = (state_d == FEED);
    drain_d = (state_d == DRAIN);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_len_q  <= '0;
      feed_k_q <= '0;
      flush_q  <= '0;
      row_q    <= '0;
      clear_q  <= 1'b0;
      feed_q   <= 1'b0;
      drain_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      feed_k_q <= feed_k_d;
      flush_q  <= flush_d;
      row_q    <= row_d;
      clear_q  <= clear_d;
      feed_q   <= feed_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  valid_skew #(.N(N), .DEPTH_OFFSET(1)) u_row_skew (
    .clk      (clk),
    .rst      (rst),
    .in_valid (feed_q),
    .out_valid(a_valid_row)
  );

  valid_skew #(.N(N), .DEPTH_OFFSET(1)) u_col_skew (
    .clk      (clk),
    .rst      (rst),
    .in_valid (feed_q),
    .out_valid(b_valid_col)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign acc_clear_block = clear_q;
  assign feed_en         = feed_q;
  assign feed_k          = feed_k_q;
  assign drain_en        = drain_q;
  assign drain_row       = row_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized + directed bench for systolic_ctrl against a timeline model
// and a small output-stationary PE array model.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int KW = 5;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst, start, res_ready;
  logic [KW-1:0] k_len;
  logic          busy, done, acc_clear_block, feed_en, drain_en;
  logic [KW-1:0] feed_k;
  logic [N-1:0]  a_valid_row, b_valid_col;
  logic [RW-1:0] drain_row;

  systolic_ctrl #(.N(N), .KW(KW), .RW(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .k_len          (k_len),
    .busy           (busy),
    .done           (done),
    .acc_clear_block(acc_clear_block),
    .feed_en        (feed_en),
    .feed_k         (feed_k),
    .a_valid_row    (a_valid_row),
    .b_valid_col    (b_valid_col),
    .drain_en       (drain_en),
    .drain_row      (drain_row),
    .res_ready      (res_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Block timeline model: accept cycle, length, handshakes so far
  bit in_blk  = 1'b0;
  int s0      = 0;
  int kk      = 0;
  int hs      = 0;
  int done_at = -1;

  // PE array model fed from the observed edge valids, all-ones operands
  logic [N-1:0] a_h [64];
  logic [N-1:0] b_h [64];
  int acc [N][N];

  int clear_cyc  = -1;
  int drain_rise = -1;
  int a_rise [N];
  int b_rise [N];
  logic [N-1:0] a_prev = '0;
  logic [N-1:0] b_prev = '0;
  logic drain_prev = 1'b0;

  function automatic bit fed(input int t);
    return in_blk && kk > 0 && t - s0 >= 2 && t - s0 < 2 + kk;
  endfunction

  function automatic int ds();
    return s0 + ((kk == 0) ? 2 : 1 + kk + 2 * N);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare();
    int r;
    bit e_clr, e_feed, e_drn, e_busy, e_done;
    int e_fk, e_row;
    logic [N-1:0] e_v;
    r      = cyc - s0;
    e_clr  = in_blk && r == 1;
    e_feed = fed(cyc);
    e_fk   = e_feed ? r - 2 : 0;
    e_drn  = in_blk && cyc >= ds();
    e_row  = e_drn ? hs : 0;
    e_busy = in_blk && r >= 1;
    e_done = (cyc == done_at);
    for (int i = 0; i < N; i++) e_v[i] = fed(cyc - 1 - i);
    chk("acc_clear_block", int'(acc_clear_block), int'(e_clr));
    chk("feed_en", int'(feed_en), int'(e_feed));
    chk("feed_k", int'(feed_k), e_fk);
    chk("a_valid_row", int'(a_valid_row), int'(e_v));
    chk("b_valid_col", int'(b_valid_col), int'(e_v));
    chk("drain_en", int'(drain_en), int'(e_drn));
    chk("drain_row", int'(drain_row), e_row);
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    a_h[cyc % 64] = a_valid_row;
    b_h[cyc % 64] = b_valid_col;
    if (acc_clear_block === 1'b1) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) acc[i][j] = 0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (cyc - j >= 0 && cyc - i >= 0) begin
          if (a_h[(cyc - j) % 64][i] === 1'b1 &&
              b_h[(cyc - i) % 64][j] === 1'b1)
            acc[i][j]++;
        end
      end
    end
    if (e_drn) begin
      for (int j = 0; j < N; j++) chk("pe_acc", acc[hs][j], kk);
    end
    if (acc_clear_block === 1'b1) clear_cyc = cyc;
    if (drain_en === 1'b1 && drain_prev !== 1'b1) drain_rise = cyc;
    for (int i = 0; i < N; i++) begin
      if (a_valid_row[i] === 1'b1 && a_prev[i] !== 1'b1) a_rise[i] = cyc;
      if (b_valid_col[i] === 1'b1 && b_prev[i] !== 1'b1) b_rise[i] = cyc;
    end
    a_prev     = a_valid_row;
    b_prev     = b_valid_col;
    drain_prev = drain_en;
  endtask

  task automatic advance(input logic st, input int kl, input logic rdy,
                         input logic rs);
    bit was_idle;
    was_idle = !in_blk;
    if (rs) begin
      in_blk  = 1'b0;
      done_at = -1;
      return;
    end
    if (in_blk && cyc >= ds() && rdy) begin
      hs++;
      if (hs == N) begin
        in_blk  = 1'b0;
        done_at = cyc + 1;
      end
    end
    if (was_idle && st) begin
      in_blk = 1'b1;
      s0     = cyc;
      kk     = kl;
      hs     = 0;
    end
  endtask

  task automatic tick(input logic st, input int kl, input logic rdy,
                      input logic rs);
    compare();
    start     = st;
    k_len     = KW'(kl);
    res_ready = rdy;
    rst       = rs;
    advance(st, kl, rdy, rs);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic finish_blk(input int stall_at, input int stall_n,
                            input bit spur, input bit rnd, output int d);
    int stalls;
    int budget;
    logic rdy;
    logic st;
    stalls = 0;
    budget = 0;
    while (in_blk && budget < 500) begin
      rdy = 1'b1;
      if (rnd) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else if (cyc >= ds() && hs == stall_at && stalls < stall_n) begin
        rdy = 1'b0;
        stalls++;
      end
      st = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      tick(st, int'($urandom_range(0, 31)), rdy, 1'b0);
      budget++;
    end
    chk("block_timeout", int'(in_blk), 0);
    d = done_at;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int s, d, d1, k;
    rst       = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_rise[i] = -1;
      b_rise[i] = -1;
    end
    @(posedge clk);
    #1;
    cyc = 0;
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 0);
    tick(1, 0, 1, 1);
    tick(0, 0, 1, 0);

    // Nominal k_len=3 timeline
    s = cyc;
    tick(1, 3, 1, 0);
    finish_blk(-1, 0, 0, 0, d);
    tick(0, 0, 1, 0);
    chk("t1_clear_cyc", clear_cyc - s, 1);
    chk("t1_a3_rise", a_rise[3] - s, 6);
    chk("t1_drain_rise", drain_rise - s, 12);
    chk("t1_done_cyc", d - s, 16);

    // Single-step skew staircase
    s = cyc;
    tick(1, 1, 1, 0);
    finish_blk(-1, 0, 0, 0, d);
    tick(0, 0, 1, 0);
    for (int i = 0; i < N; i++) begin
      chk("skew_a_rise", a_rise[i] - s, 3 + i);
      chk("skew_b_rise", b_rise[i] - s, 3 + i);
    end

    // Backpressure on row 1
    s = cyc;
    tick(1, 2, 1, 0);
    finish_blk(1, 3, 0, 0, d);
    tick(0, 0, 1, 0);
    chk("bp_done_cyc", d - s, 18);

    // Empty block
    s = cyc;
    tick(1, 0, 1, 0);
    finish_blk(-1, 0, 0, 0, d);
    tick(0, 0, 1, 0);
    chk("k0_done_cyc", d - s, 6);

    // Spurious starts, then back-to-back start in the done cycle
    s = cyc;
    tick(1, 4, 1, 0);
    finish_blk(-1, 0, 1, 0, d);
    chk("spur_done_cyc", d - s, 17);
    tick(1, 2, 1, 0);
    finish_blk(-1, 0, 0, 0, d1);
    tick(0, 0, 1, 0);
    chk("b2b_clear_cyc", clear_cyc - d, 1);
    chk("b2b_done_cyc", d1 - d, 15);

    // Reset while flushing, then a fresh block
    s = cyc;
    tick(1, 3, 1, 0);
    while (cyc < s + 8) tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)) & 1'b0, 0, 1, 0);
    s = cyc;
    tick(1, 2, 1, 0);
    finish_blk(-1, 0, 0, 0, d);
    tick(0, 0, 1, 0);
    chk("post_rst_done_cyc", d - s, 15);

    // Longest legal k_len
    s = cyc;
    tick(1, 31, 1, 0);
    finish_blk(-1, 0, 0, 0, d);
    tick(0, 0, 1, 0);
    chk("kmax_done_cyc", d - s, 31 + 2 + 7 + 4);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        tick(0, 0, 1'($urandom_range(0, 1)), 0);
      k = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 9));
      tick(1, k, 1'($urandom_range(0, 1)), 0);
      finish_blk(-1, 0, 1'($urandom_range(0, 1)), 1, d);
      tick(0, 0, 1, 0);
    end
    tick(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of MAC processing elements (PEs).
- Per C-block, on one start it: pulses acc_clear_block; issues K operand-fetch steps with row/column skewed valids; waits for the wavefront to flush; drains the accumulators row by row under a ready/valid handshake.
- Sits between the tile scheduler (start/done) and the array plus its operand buffers and result mux.

Parameters:
- N, 4, array dimension (rows = columns), N >= 2
- KW, 16, width of the K-length and k-index fields
- RW, $clog2(N), width of drain_row

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one C-block; sampled only in IDLE
- k_len  in  KW  number of MAC steps; sampled with start
- busy  out  1  high from the cycle after start is accepted until the final drain handshake
- done  out  1  one-cycle pulse in the cycle after the final drain handshake
- acc_clear_block  out  1  one-cycle clear pulse to all PEs
- feed_en  out  1  operand-buffer read enable
- feed_k  out  KW  operand-buffer read index
- a_valid_row  out  N  a_valid into the west-edge PE of row i
- b_valid_col  out  N  b_valid into the north-edge PE of column j
- drain_en  out  1  result-exposure enable to all PEs (result valid)
- drain_row  out  RW  row select for the result mux
- res_ready  in  1  downstream accepts the current row

Behaviour:
- Reset: synchronous, active-high. Every output is 0, FSM goes to IDLE, all skew registers clear. Reset mid-operation aborts the block with no done pulse.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN.
- IDLE:
  - start=1 latches k_len and moves to CLEAR.
  - start while busy is ignored.
- CLEAR (1 cycle):
  - acc_clear_block=1.
  - Next state is FEED if k_len != 0, else DRAIN (all results zero).
- FEED (k_len cycles):
  - feed_en=1; feed_k counts 0 .. k_len-1.
  - After the cycle with feed_k = k_len-1, go to FLUSH.
  - feed_k is 0 outside FEED.
- Operand buffer read latency is 1 cycle:
  - a_valid_row[i] = feed_en delayed 1+i cycles.
  - b_valid_col[j] = feed_en delayed 1+j cycles.
  - Implemented as an N-deep shift register, so the first valid arrives 2 cycles after the clear.
- FLUSH:
  - Lasts exactly 2N-1 cycles, driven by a down-counter.
  - If the last FEED is cycle T, PE(N-1,N-1) performs its last MAC in cycle T+2N-1, and DRAIN starts at T+2N.
  - Skew registers keep shifting during FLUSH and are all zero by the time DRAIN starts.
- DRAIN:
  - drain_en=1; drain_row starts at 0.
  - A handshake occurs when drain_en & res_ready; drain_row then increments.
  - If res_ready=0, drain_row and drain_en hold.
  - The handshake with drain_row = N-1 sends the FSM to IDLE with done=1 and busy=0 in the next cycle.
- Outputs are registered:
  - acc_clear_block, feed_en, drain_en and drain_row change only on clock edges.
  - feed_en and acc_clear_block are never high together.
  - drain_en is never high while any bit of a_valid_row or b_valid_col is high.
- k_len = all-ones is legal: the counter is KW bits wide and must not wrap early.
- A start in the same cycle done is high is accepted, since the FSM is in IDLE then; a back-to-back block begins CLEAR the cycle after.

Decomposition:
- Package systolic_pkg holds:
  - state enum ctrl_state_e {IDLE, CLEAR, FEED, FLUSH, DRAIN}
  - localparam function flush_cycles(N) = 2*N-1
- Sub-module valid_skew (parameter N, DEPTH_OFFSET=1): an N-tap shift register producing the skewed valid vector from feed_en. It is instantiated twice, for rows and columns.

Test Plan:
- N=4, k_len=3, res_ready=1:
  - CLEAR at cycle 1, feed_k 0,1,2 at cycles 2-4.
  - a_valid_row[3] high at cycles 6-8.
  - FLUSH cycles 5-11; drain_en cycles 12-15 with drain_row 0..3.
  - done at cycle 16.
- Skew check with k_len=1: each a_valid_row[i] and b_valid_col[i] pulses for exactly one cycle at cycle 3+i (CLEAR=1). A PE-array model fed with all-ones operands drains all accumulators = 1.
- Backpressure, N=4, k_len=2: res_ready low for 3 cycles at drain_row=1 -> drain_row holds at 1 and drain_en stays high; done is delayed by exactly 3 cycles.
- k_len=0: CLEAR then immediate DRAIN. feed_en and all valids stay 0; four rows drain with zero results; done follows.
- start pulsed during FEED is ignored; start asserted in the done cycle starts a new CLEAR in the next cycle.
- rst asserted in FLUSH: the next cycle has all outputs 0, state IDLE and no done. A fresh start with k_len=2 completes normally.
